video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Fully parametrised raster timing generator for the video controller. It replaces fixed-mode HS/VS/BLANK generation.
- Emits a look-ahead pixel request stream (req_valid/req_x/req_y) for the framebuffer read path, and a delayed, aligned display stream (hs, vs, blank, x, y) towards video_if.
- Sits between the pixel-clock domain reset logic and the framebuffer FIFO / video_if output stage.

Parameters:
- HDISP, 800, active pixels per line
- HFP, 40, horizontal front porch (pixels)
- HPULSE, 48, horizontal sync pulse width (pixels)
- HBP, 40, horizontal back porch (pixels)
- VDISP, 480, active lines per frame
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync pulse width (lines)
- VBP, 29, vertical back porch (lines)
- HS_POL, 0, asserted level of hs (0 = active-low)
- VS_POL, 0, asserted level of vs
- LOOKAHEAD, 2, extra cycles by which requests lead display (0..8)
- FCW, 16, frame counter width

Ports:
- pixel_clk  in  1  pixel clock, all logic on rising edge
- pixel_rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; 0 freezes the whole block
- req_valid  out  1  requested coordinate is in the active area
- req_x  out  $clog2(HDISP)  requested column
- req_y  out  $clog2(VDISP)  requested line
- hs  out  1  horizontal sync, polarity HS_POL
- vs  out  1  vertical sync, polarity VS_POL
- blank  out  1  1 = active display pixel, 0 = blanking
- x  out  $clog2(HDISP)  displayed column (0 outside active area)
- y  out  $clog2(VDISP)  displayed line (0 outside active area)
- sof  out  1  one-cycle pulse with displayed pixel (0,0)
- eol  out  1  one-cycle pulse with displayed pixel (HDISP-1, any active line)
- frame_cnt  out  FCW  completed frames, increments with sof

Behaviour:
- Line and frame totals:
  - HTOT = HDISP+HFP+HPULSE+HBP.
  - VTOT = VDISP+VFP+VPULSE+VBP.
- Internal counters:
  - hcnt runs 0..HTOT-1; vcnt runs 0..VTOT-1.
  - hcnt wraps to 0 and increments vcnt. vcnt wraps to 0 after VTOT-1.
  - Both reset to 0 and advance only when en=1.
- Region layout is active first, then front porch, sync, back porch:
  - Active pixel: hcnt<HDISP and vcnt<VDISP.
  - hs asserted for hcnt in [HDISP+HFP, HDISP+HFP+HPULSE).
  - vs asserted for vcnt in [VDISP+VFP, VDISP+VFP+VPULSE), over whole lines.
- Request stage (registered, 1 cycle latency):
  - On each en=1 edge, req_* reflect the pre-edge counter value.
  - req_valid = active(hcnt,vcnt).
  - req_x/req_y = counters when active, else 0.
- Display stage:
  - Request-stage values pass through a LOOKAHEAD-deep register pipe.
  - hs/vs/blank/x/y/sof/eol therefore appear exactly LOOKAHEAD cycles after the matching req_* value.
  - LOOKAHEAD=0 makes both streams coincident.
- sof: asserted with displayed (0,0). frame_cnt increments on the same edge that sof rises, and wraps modulo 2^FCW.
- Reset (asynchronous, all pipe stages):
  - req_valid=0, req_x=0, req_y=0.
  - hs=~HS_POL, vs=~VS_POL, blank=0, x=0, y=0, sof=0, eol=0, frame_cnt=0.
- First edge after reset release with en=1: req_valid=1, req_x=0, req_y=0.
- en=0:
  - Counters and pipe hold their values.
  - sof/eol forced to 0 while en=0, with no re-pulse on resume.
  - frame_cnt holds.
- Reset mid-frame: immediate return to reset values; restarts at (0,0).
- Elaboration check: each porch/pulse parameter must be ≥1 and LOOKAHEAD ≤ 8, else $error.

Optional Feature:
- Macro: VIDEO_TPG_EN.
- Defined:
  - Adds output rgb (24 bits), aligned with the display stream.
  - Eight vertical colour bars of width HDISP/8: white, yellow, cyan, green, magenta, red, blue, black (0xFFFFFF .. 0x000000).
  - rgb=0 when blank=0 and in reset.
- Undefined: no rgb port, no TPG logic.

Test Plan:
Shared config: HDISP=160, HFP=2, HPULSE=4, HBP=6 (HTOT=172); VDISP=90, VFP=1, VPULSE=2, VBP=3 (VTOT=96); LOOKAHEAD=2.
- Release reset with en=1 -> edge 1: req_valid=1 (0,0); edge 3: blank=1, x=0, y=0, sof=1, frame_cnt=1; hs=1, vs=1 (active-low idle).
- Line timing -> each line blank=1 for 160 cycles then 0 for 12; hs=0 for exactly 4 cycles starting 162 cycles after the line's first pixel; eol on x=159.
- Frame timing -> vs=0 for exactly 2×172=344 cycles starting at line 91; frame period 16512 cycles; frame_cnt=3 after third sof.
- en=0 for 50 cycles mid-line at x=80 -> all outputs frozen, no sof/eol; after resume x continues 81 and the period is extended by exactly 50.
- Assert pixel_rst_n low at line 40 -> outputs at reset values immediately, without waiting for a clock edge; restart at (0,0) with frame_cnt=1.
- VIDEO_TPG_EN defined -> x=0..19 gives rgb=0xFFFFFF, x=140..159 gives 0x000000, blanking gives 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: look-ahead pixel request stream plus an aligned,
// LOOKAHEAD-delayed display stream. Define VIDEO_TPG_EN to add a colour-bar rgb output.
module video_timing_gen #(
    parameter int unsigned HDISP     = 800,
    parameter int unsigned HFP       = 40,
    parameter int unsigned HPULSE    = 48,
    parameter int unsigned HBP       = 40,
    parameter int unsigned VDISP     = 480,
    parameter int unsigned VFP       = 13,
    parameter int unsigned VPULSE    = 3,
    parameter int unsigned VBP       = 29,
    parameter int unsigned HS_POL    = 0,
    parameter int unsigned VS_POL    = 0,
    parameter int unsigned LOOKAHEAD = 2,
    parameter int unsigned FCW       = 16
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst_n,
    input  logic                       en,
    output logic                       req_valid,
    output logic [$clog2(HDISP)-1:0]   req_x,
    output logic [$clog2(VDISP)-1:0]   req_y,
    output logic                       hs,
    output logic                       vs,
    output logic                       blank,
    output logic [$clog2(HDISP)-1:0]   x,
    output logic [$clog2(VDISP)-1:0]   y,
    output logic                       sof,
    output logic                       eol,
    output logic [FCW-1:0]             frame_cnt
`ifdef VIDEO_TPG_EN
    ,
    output logic [23:0]                rgb
`endif
);

    localparam int unsigned HTOT = HDISP + HFP + HPULSE + HBP;
    localparam int unsigned VTOT = VDISP + VFP + VPULSE + VBP;
    localparam int unsigned HW   = $clog2(HTOT);
    localparam int unsigned VW   = $clog2(VTOT);
    localparam int unsigned XW   = $clog2(HDISP);
    localparam int unsigned YW   = $clog2(VDISP);

    localparam logic [HW-1:0] HDISP_L  = HW'(HDISP);
    localparam logic [HW-1:0] XLAST_L  = HW'(HDISP - 1);
    localparam logic [HW-1:0] HS_START = HW'(HDISP + HFP);
    localparam logic [HW-1:0] HS_END   = HW'(HDISP + HFP + HPULSE);
    localparam logic [HW-1:0] HLAST_L  = HW'(HTOT - 1);
    localparam logic [VW-1:0] VDISP_L  = VW'(VDISP);
    localparam logic [VW-1:0] VS_START = VW'(VDISP + VFP);
    localparam logic [VW-1:0] VS_END   = VW'(VDISP + VFP + VPULSE);
    localparam logic [VW-1:0] VLAST_L  = VW'(VTOT - 1);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    if (HFP < 1 || HPULSE < 1 || HBP < 1 || VFP < 1 || VPULSE < 1 || VBP < 1
        || LOOKAHEAD > 8) begin : g_param_err
        $error("video_timing_gen: porch/pulse must be >= 1 and LOOKAHEAD <= 8");
    end

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          blank;
        logic          sof;
        logic          eol;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } disp_t;

    localparam disp_t DISP_RST = '{hs: ~HS_ON, vs: ~VS_ON, blank: 1'b0, sof: 1'b0, eol: 1'b0,
                                   x: '0, y: '0};

    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;
    logic [FCW-1:0] frame_cnt_q;
    logic           held_q;
    logic           active;
    disp_t          req_d;
    disp_t          disp;
    // stage 0 is the request stage, stage LOOKAHEAD drives the display outputs
    disp_t          stage_q [LOOKAHEAD+1];
    disp_t          stage_d [LOOKAHEAD+1];

    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == HLAST_L) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VLAST_L) ? '0 : vcnt_q + VW'(1);
        end
    end

    always_comb begin
        active      = (hcnt_q < HDISP_L) && (vcnt_q < VDISP_L);
        req_d       = DISP_RST;
        req_d.blank = active;
        req_d.x     = active ? XW'(hcnt_q) : '0;
        req_d.y     = active ? YW'(vcnt_q) : '0;
        req_d.hs    = (hcnt_q >= HS_START && hcnt_q < HS_END) ? HS_ON : ~HS_ON;
        req_d.vs    = (vcnt_q >= VS_START && vcnt_q < VS_END) ? VS_ON : ~VS_ON;
        req_d.sof   = (hcnt_q == '0) && (vcnt_q == '0);
        req_d.eol   = active && (hcnt_q == XLAST_L);
        stage_d[0]  = req_d;
        for (int i = 1; i <= LOOKAHEAD; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
            held_q      <= 1'b0;
            for (int i = 0; i <= LOOKAHEAD; i++) begin
                stage_q[i] <= DISP_RST;
            end
        end else if (en) begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            held_q <= 1'b0;
            for (int i = 0; i <= LOOKAHEAD; i++) begin
                stage_q[i] <= stage_d[i];
            end
            if (stage_d[LOOKAHEAD].sof) begin
                frame_cnt_q <= frame_cnt_q + FCW'(1);
            end
        end else begin
            held_q <= 1'b1;
        end
    end

    // held_q masks the stale sof/eol still sitting in the pipe for the first cycle after resume
    always_comb begin
        disp      = stage_q[LOOKAHEAD];
        req_valid = stage_q[0].blank;
        req_x     = stage_q[0].x;
        req_y     = stage_q[0].y;
        hs        = disp.hs;
        vs        = disp.vs;
        blank     = disp.blank;
        x         = disp.x;
        y         = disp.y;
        sof       = disp.sof & en & ~held_q;
        eol       = disp.eol & en & ~held_q;
        frame_cnt = frame_cnt_q;
    end

`ifdef VIDEO_TPG_EN
    localparam int unsigned   BARW   = (HDISP >= 8) ? HDISP / 8 : 1;
    localparam logic [XW-1:0] BARW_L = XW'(BARW);

    logic [XW-1:0] bar_idx;
    logic [2:0]    bar;
    logic [23:0]   colour;

    always_comb begin
        bar_idx = disp.x / BARW_L;
        bar     = (bar_idx > XW'(7)) ? 3'd7 : bar_idx[2:0];
        case (bar)
            3'd0:    colour = 24'hFFFFFF;
            3'd1:    colour = 24'hFFFF00;
            3'd2:    colour = 24'h00FFFF;
            3'd3:    colour = 24'h00FF00;
            3'd4:    colour = 24'hFF00FF;
            3'd5:    colour = 24'hFF0000;
            3'd6:    colour = 24'h0000FF;
            default: colour = 24'h000000;
        endcase
        rgb = disp.blank ? colour : 24'h000000;
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: startup latency, line/frame timing, stall and
// mid-frame reset, plus colour bars when VIDEO_TPG_EN is defined.
module tb_video_timing_gen;

    localparam int HTOT = 172;
    localparam int FTOT = 16512;
    localparam int LA   = 2;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst_n = 1'b0;
    logic        en = 1'b0;
    logic        req_valid;
    logic [7:0]  req_x;
    logic [6:0]  req_y;
    logic        hs, vs, blank, sof, eol;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [15:0] frame_cnt;
`ifdef VIDEO_TPG_EN
    logic [23:0] rgb;
`endif

    video_timing_gen #(
        .HDISP(160), .HFP(2), .HPULSE(4), .HBP(6),
        .VDISP(90), .VFP(1), .VPULSE(2), .VBP(3),
        .HS_POL(0), .VS_POL(0), .LOOKAHEAD(LA), .FCW(16)
    ) dut (
        .pixel_clk  (pixel_clk),
        .pixel_rst_n(pixel_rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .x          (x),
        .y          (y),
        .sof        (sof),
        .eol        (eol),
        .frame_cnt  (frame_cnt)
`ifdef VIDEO_TPG_EN
        ,
        .rgb        (rgb)
`endif
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;
    int p = 0;
    int cyc = 0;
    int sof_cyc[$];
    bit stats_on = 1'b0;
    int hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1, eol_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // packed {blank, hs, vs, sof, eol, x[7:0], y[6:0]} for display position pp
    function automatic logic [19:0] exp_disp(input int pp);
        int   hd  = pp % HTOT;
        int   vd  = (pp / HTOT) % 96;
        logic act = (hd < 160) && (vd < 90);
        return {act, !(hd >= 162 && hd < 166), !(vd >= 91 && vd < 93), (pp % FTOT) == 0,
                act && (hd == 159), act ? 8'(hd) : 8'd0, act ? 7'(vd) : 7'd0};
    endfunction

    function automatic logic [15:0] exp_req(input int pp);
        int   hd  = pp % HTOT;
        int   vd  = (pp / HTOT) % 96;
        logic act = (hd < 160) && (vd < 90);
        return {act, act ? 8'(hd) : 8'd0, act ? 7'(vd) : 7'd0};
    endfunction

    function automatic logic [23:0] exp_rgb(input int pp);
        logic [19:0] e = exp_disp(pp);
        logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return e[19] ? bars[(pp % HTOT) / 20] : 24'h0;
    endfunction

    task automatic tick();
        @(posedge pixel_clk);
        #1;
        cyc++;
    endtask

    task automatic check_model();
        logic [19:0] e = exp_disp(p);
        if (!en) e[16:15] = 2'b00;
        check("disp", {blank, hs, vs, sof, eol, x, y}, e);
        check("req", {req_valid, req_x, req_y}, exp_req(p + LA));
        check("frame_cnt", frame_cnt, p / FTOT + 1);
`ifdef VIDEO_TPG_EN
        check("rgb", rgb, exp_rgb(p));
`endif
    endtask

    task automatic step();
        tick();
        if (en) p++;
        check_model();
        if (sof) sof_cyc.push_back(cyc);
        if (stats_on) begin
            if (p < HTOT && !hs) begin
                if (hs_first < 0) hs_first = p;
                hs_cnt++;
            end
            if (!vs) begin
                if (vs_first < 0) vs_first = p;
                vs_cnt++;
            end
            if (eol) eol_cnt++;
        end
    endtask

    task automatic run_to(input int target);
        while (p < target) step();
    endtask

    task automatic reset_values(input string tag);
        check({tag, " req"}, {req_valid, req_x, req_y}, 16'h0);
        check({tag, " ctl"}, {hs, vs, blank, sof, eol}, 5'b11000);
        check({tag, " xy"}, {x, y}, 15'h0);
        check({tag, " frame_cnt"}, frame_cnt, 0);
`ifdef VIDEO_TPG_EN
        check({tag, " rgb"}, rgb, 0);
`endif
    endtask

    task automatic start_frame();
        @(negedge pixel_clk);
        pixel_rst_n = 1'b1;
        tick();
        check("e1 req", {req_valid, req_x, req_y}, {1'b1, 8'd0, 7'd0});
        check("e1 blank", blank, 0);
        tick();
        check("e2 req_x", req_x, 1);
        check("e2 blank sof", {blank, sof}, 2'b00);
        tick();
        check("e3 blank sof", {blank, sof}, 2'b11);
        check("e3 xy", {x, y}, 15'h0);
        check("e3 frame_cnt", frame_cnt, 1);
        check("e3 hs vs", {hs, vs}, 2'b11);
        p = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b1;
        pixel_rst_n = 1'b0;
        #23;
        reset_values("por");
        start_frame();
        sof_cyc.push_back(cyc);

        stats_on = 1'b1;
        run_to(FTOT - 1);
        stats_on = 1'b0;
        check("hs low count", hs_cnt, 4);
        check("hs low start", hs_first, 162);
        check("vs low count", vs_cnt, 344);
        check("vs low start", vs_first, 91 * HTOT);
        check("eol count", eol_cnt, 90);

        // 50-cycle stall at displayed (80, 5) of frame 2
        run_to(FTOT + 5 * HTOT + 80);
        check("pre-stall x", x, 80);
        en = 1'b0;
        repeat (50) step();
        en = 1'b1;
        step();
        check("resume x", x, 81);

        run_to(2 * FTOT);
        check("third sof frame_cnt", frame_cnt, 3);
        check("sof count", sof_cyc.size(), 3);
        if (sof_cyc.size() >= 3) begin
            check("period 1", sof_cyc[1] - sof_cyc[0], FTOT);
            check("period 2", sof_cyc[2] - sof_cyc[1], FTOT + 50);
        end

        // stall on an eol pixel: masked while stalled and not re-pulsed on resume
        run_to(2 * FTOT + 10 * HTOT + 159);
        check("eol before stall", eol, 1);
        en = 1'b0;
        #1;
        check("eol while stalled", eol, 0);
        repeat (3) step();
        en = 1'b1;
        #1;
        check("eol on resume", eol, 0);
        step();

        // asynchronous reset mid-frame at line 40
        run_to(2 * FTOT + 40 * HTOT + 10);
        #2;
        pixel_rst_n = 1'b0;
        #1;
        reset_values("mid rst");
        tick();
        tick();
        reset_values("rst held");
        start_frame();
        run_to(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
